// File: rtl/srcnn_mac_pkg.sv
// rtl/srcnn_mac_pkg.sv - shared types and default widths for the SRCNN MAC accumulator
package srcnn_mac_pkg;

    // Default datapath sizing for a 3x3 conv layer
    localparam int PROD_WIDTH    = 10;
    localparam int BIAS_WIDTH    = 12;
    localparam int ACC_WIDTH     = 18;
    localparam int OUT_WIDTH     = 8;
    localparam int SHIFT         = 4;
    localparam int TAPS          = 9;

    // Tap counter only ever reaches TAPS-1
    localparam int TAP_CNT_WIDTH = $clog2(TAPS);

    // Accumulating taps, or presenting a finished pixel downstream
    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_e;

endpackage

// File: rtl/srcnn_relu_sat.sv
// rtl/srcnn_relu_sat.sv - rescale shift, optional round-half-up (SRCNN_MAC_ROUND_EN), ReLU and saturation
module srcnn_relu_sat #(
    parameter int ACC_WIDTH = 18,
    parameter int SHIFT     = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    output logic [OUT_WIDTH-1:0] pix_o
);

    // One guard bit so the rounding offset cannot wrap the most positive sum
    localparam int EW = ACC_WIDTH + 1;

    logic signed [EW-1:0] ext_s;
    logic signed [EW-1:0] shifted_s;

`ifdef SRCNN_MAC_ROUND_EN
    localparam logic [EW-1:0] ROUND_C = EW'(2 ** (SHIFT - 1));
    assign ext_s = $signed({acc_i[ACC_WIDTH-1], acc_i}) + $signed(ROUND_C);
`else
    assign ext_s = $signed({acc_i[ACC_WIDTH-1], acc_i});
`endif

    assign shifted_s = ext_s >>> SHIFT;

    // Negative clamps to zero, anything above the pixel range saturates to all-ones
    always_comb begin
        pix_o = shifted_s[OUT_WIDTH-1:0];
        if (shifted_s[EW-1]) begin
            pix_o = '0;
        end else if (|shifted_s[EW-2:OUT_WIDTH]) begin
            pix_o = '1;
        end
    end

endmodule

// File: rtl/srcnn_mac_acc.sv
// rtl/srcnn_mac_acc.sv - per-pixel tap accumulator with bias, rescale, ReLU and saturation (SRCNN_MAC_ROUND_EN selects rounding)
module srcnn_mac_acc #(
    parameter int PROD_WIDTH = srcnn_mac_pkg::PROD_WIDTH,
    parameter int BIAS_WIDTH = srcnn_mac_pkg::BIAS_WIDTH,
    parameter int TAPS       = srcnn_mac_pkg::TAPS,
    parameter int ACC_WIDTH  = srcnn_mac_pkg::ACC_WIDTH,
    parameter int SHIFT      = srcnn_mac_pkg::SHIFT,
    parameter int OUT_WIDTH  = srcnn_mac_pkg::OUT_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_din,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [BIAS_WIDTH-1:0] bias_din,
    output logic [OUT_WIDTH-1:0]  out_dout,
    output logic                  out_valid,
    input  logic                  out_ready
);

    import srcnn_mac_pkg::*;

    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       tap_cnt_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic [OUT_WIDTH-1:0]   dout_q;
    logic                   valid_q;
    logic                   ready_q;
    logic                   prod_hs;
    logic                   last_tap;
    logic [OUT_WIDTH-1:0]   pix;

    assign prod_hs  = prod_valid & ready_q;
    assign last_tap = (tap_cnt_q == LAST_TAP);

    // Running sum including the product on the input; bias seeds the first tap
    always_comb begin
        acc_d = acc_q;
        if (tap_cnt_q == '0) begin
            acc_d = {{(ACC_WIDTH-BIAS_WIDTH){bias_din[BIAS_WIDTH-1]}}, bias_din}
                  + {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, prod_din};
        end else begin
            acc_d = acc_q + {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, prod_din};
        end
    end

    // Pixel is computed from the sum that already includes the last product
    srcnn_relu_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_relu_sat (
        .acc_i (acc_d),
        .pix_o (pix)
    );

    // Two-state control with registered handshake outputs; no accept/emit bypass
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= ACCUM;
            tap_cnt_q <= '0;
            acc_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (prod_hs) begin
                        acc_q <= acc_d;
                        if (last_tap) begin
                            tap_cnt_q <= '0;
                            dout_q    <= pix;
                            valid_q   <= 1'b1;
                            ready_q   <= 1'b0;
                            state_q   <= OUTPUT;
                        end else begin
                            tap_cnt_q <= tap_cnt_q + CNT_W'(1);
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign prod_ready = ready_q;
    assign out_valid  = valid_q;
    assign out_dout   = dout_q;

endmodule

// File: tb/tb_srcnn_mac_acc.sv
// tb/tb_srcnn_mac_acc.sv - self-checking bench for srcnn_mac_acc against a plain-arithmetic pixel model
module tb_srcnn_mac_acc;

    import srcnn_mac_pkg::*;

    logic                  ap_clk = 1'b0;
    logic                  ap_rst = 1'b1;
    logic [PROD_WIDTH-1:0] prod_din = '0;
    logic                  prod_valid = 1'b0;
    logic                  prod_ready;
    logic [BIAS_WIDTH-1:0] bias_din = '0;
    logic [OUT_WIDTH-1:0]  out_dout;
    logic                  out_valid;
    logic                  out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int prod_arr [TAPS];

    always #5 ap_clk = ~ap_clk;

    srcnn_mac_acc dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .prod_din   (prod_din),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .bias_din   (bias_din),
        .out_dout   (out_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference pixel: integer sum, floor or half-up divide by 2^SHIFT, then ReLU and clamp
    function automatic int model_pixel(input int bias);
        int s;
        int q;
        s = bias;
        for (int i = 0; i < TAPS; i++) s += prod_arr[i];
`ifdef SRCNN_MAC_ROUND_EN
        s += 2 ** (SHIFT - 1);
`endif
        q = s >>> SHIFT;
        if (q < 0) q = 0;
        if (q > 2 ** OUT_WIDTH - 1) q = 2 ** OUT_WIDTH - 1;
        return q;
    endfunction

    task automatic send_prod(input int p, input int b);
        int waitc = 0;
        prod_din   = PROD_WIDTH'(p);
        bias_din   = BIAS_WIDTH'(b);
        prod_valid = 1'b1;
        while (!prod_ready && waitc < 50) begin
            @(posedge ap_clk); #1;
            waitc++;
        end
        if (waitc >= 50) check("prod_timeout", 0, 1);
        @(posedge ap_clk); #1;
        prod_valid = 1'b0;
        bias_din   = BIAS_WIDTH'($urandom);
    endtask

    // One full window: random gaps between taps, junk bias on later taps, hold cycles of backpressure
    task automatic run_window(input string tag, input int bias, input int exp,
                              input int gap_max, input int hold);
        for (int t = 0; t < TAPS; t++) begin
            repeat ($urandom_range(0, gap_max)) begin
                prod_valid = 1'b0;
                prod_din   = PROD_WIDTH'($urandom);
                @(posedge ap_clk); #1;
            end
            send_prod(prod_arr[t], (t == 0) ? bias : int'($urandom));
        end
        check({tag, "_lat_valid"}, int'(out_valid), 1);
        check({tag, "_dout"}, int'(out_dout), exp);
        for (int h = 0; h < hold; h++) begin
            prod_valid = 1'b1;
            prod_din   = PROD_WIDTH'($urandom);
            @(posedge ap_clk); #1;
            check({tag, "_bp_dout"}, int'(out_dout), exp);
            check({tag, "_bp_valid"}, int'(out_valid), 1);
            check({tag, "_bp_pready"}, int'(prod_ready), 0);
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge ap_clk); #1;
        out_ready  = 1'b0;
        check({tag, "_acc_valid"}, int'(out_valid), 0);
        check({tag, "_acc_pready"}, int'(prod_ready), 1);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < TAPS; i++) prod_arr[i] = v;
    endtask

    task automatic pulse_reset();
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        check("rst_pready", int'(prod_ready), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_dout", int'(out_dout), 0);
    endtask

    initial begin
        int rb;
        int pmax;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("reset_pready", int'(prod_ready), 1);
        check("reset_valid", int'(out_valid), 0);
        check("reset_dout", int'(out_dout), 0);

        fill(16);
        run_window("basic", 0, 9, 0, 0);
        fill(10);
        run_window("negbias", -200, 0, 0, 0);
        fill(1023);
        run_window("sat", 0, 255, 0, 0);
        fill(0);
        prod_arr[0] = 24;
`ifdef SRCNN_MAC_ROUND_EN
        run_window("round", 0, 2, 0, 0);
`else
        run_window("round", 0, 1, 0, 0);
`endif
        fill(16);
        run_window("bp", 0, 9, 0, 5);
        run_window("gaps", 0, 9, 4, 2);

        // Partial window is discarded by reset
        for (int i = 0; i < 4; i++) send_prod(100, 0);
        pulse_reset();
        fill(16);
        run_window("rst_mid", 0, 9, 1, 0);

        // Pending pixel is discarded by reset
        fill(1023);
        for (int i = 0; i < TAPS; i++) send_prod(prod_arr[i], 0);
        check("rst_out_pending", int'(out_valid), 1);
        pulse_reset();
        fill(16);
        run_window("after_rst_out", 0, 9, 0, 1);

        for (int n = 0; n < 24; n++) begin
            rb   = int'($urandom_range(0, 4095)) - 2048;
            pmax = (n % 3 == 0) ? 1023 : ((n % 3 == 1) ? 255 : 40);
            for (int i = 0; i < TAPS; i++) prod_arr[i] = int'($urandom_range(0, pmax));
            run_window("rand", rb, model_pixel(rb), 3, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/srcnn_mac_acc.md
Name: srcnn_mac_acc

Overview:
- Downstream consumer of the conv-layer product stream: the unsigned tap products from the multiplier stage (10-bit) arrive one per handshake.
- Accumulates TAPS products per output pixel, with a signed per-pixel bias added at the first tap.
- Applies an arithmetic right shift (fixed-point rescale), then ReLU, then saturation to an unsigned pixel.
- Emits one pixel per kernel window on a valid/ready output.

Parameters:
- PROD_WIDTH, 10, width of unsigned product input.
- BIAS_WIDTH, 12, width of signed bias input.
- TAPS, 9, products per output pixel (3x3 kernel); must be >= 2.
- ACC_WIDTH, 18, signed accumulator width; must hold TAPS*(2^PROD_WIDTH-1)+2^(BIAS_WIDTH-1).
- SHIFT, 4, arithmetic right shift applied before clamping; must be >= 1.
- OUT_WIDTH, 8, unsigned output pixel width.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  reset.
- prod_din  in  PROD_WIDTH  unsigned product.
- prod_valid  in  1  product valid.
- prod_ready  out  1  block can accept a product.
- bias_din  in  BIAS_WIDTH  signed bias; sampled only on the first-tap handshake.
- out_dout  out  OUT_WIDTH  result pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- One clock, ap_clk; reset ap_rst is synchronous and active-high.
- Reset values: state=ACCUM, tap_cnt=0, acc=0, out_dout=0, out_valid=0. prod_ready=1 on the first cycle after reset deasserts.
- FSM has two states.
  - ACCUM: prod_ready=1, out_valid=0.
  - OUTPUT: prod_ready=0, out_valid=1.
- Product handshake: prod_valid & prod_ready.
  - When tap_cnt==0: acc <= sext(bias_din) + zext(prod_din).
  - Otherwise: acc <= acc + zext(prod_din).
  - tap_cnt increments by 1.
- Window completion: on the handshake with tap_cnt==TAPS-1:
  - tap_cnt <= 0; state <= OUTPUT.
  - out_dout <= clamp(final_sum >>> SHIFT), where final_sum includes this last product.
  - Latency: out_valid rises the cycle after the TAPS-th product handshake.
- Clamp rules:
  - Negative shifted value -> 0 (ReLU).
  - Value > 2^OUT_WIDTH-1 -> 2^OUT_WIDTH-1.
  - Otherwise the low OUT_WIDTH bits.
  - Shift is arithmetic on the full ACC_WIDTH signed value.
- Output handshake: out_valid & out_ready in OUTPUT -> state <= ACCUM.
  - prod_ready reasserts the following cycle; there is no same-cycle bypass.
- Backpressure: while out_ready=0 in OUTPUT, out_dout and out_valid hold stable and no products are accepted.
- prod_valid low in ACCUM: acc and tap_cnt hold; gaps between taps of any length are legal.
- Reset mid-window or mid-output: the partial sum and any pending pixel are discarded; the next product is treated as tap 0.
- The accumulator never overflows within the parameter constraints; no wrap handling is required.

Optional Feature:
- Macro: SRCNN_MAC_ROUND_EN.
- Defined: round-half-up; the clamp operates on (final_sum + 2^(SHIFT-1)) >>> SHIFT.
- Undefined: truncation (floor) via plain arithmetic shift.
- Latency and handshake behaviour are identical in both builds.

Decomposition:
- Shared package srcnn_mac_pkg holds:
  - The state enum (ACCUM, OUTPUT).
  - Default width constants (PROD_WIDTH, BIAS_WIDTH, ACC_WIDTH, OUT_WIDTH, SHIFT, TAPS).
  - A tap-counter width constant, $clog2(TAPS).
- One sub-module, srcnn_relu_sat: combinational shift, optional round, ReLU and saturation from ACC_WIDTH to OUT_WIDTH. It is reused by later layers.

Test Plan:
- Basic window: bias=0, 9 products of 16 (sum 144) -> out_dout=9, out_valid one cycle after the 9th handshake.
- Negative bias: bias=-200, 9 products of 10 (sum -110) -> out_dout=0.
- Saturation: bias=0, 9 products of 1023 (sum 9207, >>>4=575) -> out_dout=255.
- Rounding: bias=0, products 24,0,0,0,0,0,0,0,0 -> out_dout=1 without SRCNN_MAC_ROUND_EN, 2 with it.
- Backpressure: hold out_ready=0 for 5 cycles after a window completes -> out_dout stable, prod_ready=0 throughout, accept on the 6th cycle, prod_ready=1 the next cycle. Also drive random prod_valid gaps and check the result is unchanged.
- Reset mid-window: 4 products of 100, 1-cycle ap_rst, then bias=0 and 9 products of 16 -> out_dout=9 (partial sum discarded).
